// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MFHI    = 4'd7,
        MFLO    = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply/divide core producing a 64-bit {hi,lo} result
// and a divide-by-zero flag.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic        is_signed;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        is_signed = (op_i == MULT) || (op_i == DIV);
        is_div    = (op_i == DIV) || (op_i == DIVU);

        // Low 64 bits of the sign-extended product equal the signed product.
        a_ext = {{32{is_signed & a_i[31]}}, a_i};
        b_ext = {{32{is_signed & b_i[31]}}, b_i};
        prod  = a_ext * b_ext;

        // Divide on magnitudes so -2^31 / -1 wraps deterministically.
        a_neg = is_signed & a_i[31];
        b_neg = is_signed & b_i[31];
        a_mag = a_neg ? (32'd0 - a_i) : a_i;
        b_mag = b_neg ? (32'd0 - b_i) : b_i;
        q_mag = (b_i == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag = (b_i == 32'd0) ? 32'd0 : (a_mag % b_mag);
        quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;

        div_zero_o = is_div && (b_i == 32'd0);

        result_o = 64'd0;
        if (op_i == MULT || op_i == MULTU) begin
            result_o = prod;
        end else if (is_div) begin
            result_o = {rem, quot};
        end
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller: IDLE/BUSY FSM with latency counter,
// HI/LO ownership, mfhi/mflo read port and the MD stall request.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [3:0]  op_E,
    input  logic [31:0] a_E,
    input  logic [31:0] b_E,
    input  logic        md_inst_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        sh_hi_q, sh_hi_d;
    logic [31:0]        sh_lo_q, sh_lo_d;
    logic [63:0]        arith_result;
    logic               div_zero;
    logic               start_long;
    logic               is_mult_op;
    logic               last_cycle;

    md_arith u_arith (
        .op_i       (op_E),
        .a_i        (a_E),
        .b_i        (b_E),
        .result_o   (arith_result),
        .div_zero_o (div_zero)
    );

    assign start_long = start_E & is_long_op(op_E);
    assign is_mult_op = (op_E == MULT) || (op_E == MULTU);
    assign last_cycle = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_long) state_d = BUSY;
            BUSY:    if (last_cycle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A divide by zero latches the current HI/LO so the commit is a no-op.
    always_comb begin
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        if (state_q == IDLE) begin
            if (start_long) begin
                cnt_d = is_mult_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                if (div_zero) begin
                    sh_hi_d = hi_q;
                    sh_lo_d = lo_q;
                end else begin
                    sh_hi_d = arith_result[63:32];
                    sh_lo_d = arith_result[31:0];
                end
            end else if (start_E && op_E == MTHI) begin
                hi_d = a_E;
            end else if (start_E && op_E == MTLO) begin
                lo_d = a_E;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (last_cycle) begin
                hi_d = sh_hi_q;
                lo_d = sh_lo_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

    // Stall covers the cycle a long op sits in E as well as the busy period.
    always_comb begin
        busy     = (state_q == BUSY);
        stall_md = md_inst_D & (busy | start_long);
        hi       = hi_q;
        lo       = lo_q;
        md_rdata = 32'd0;
        if (op_E == MFHI) begin
            md_rdata = hi_q;
        end else if (op_E == MFLO) begin
            md_rdata = lo_q;
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed plus randomized bench for md_unit_ctrl against a longint-arithmetic
// reference model of HI/LO and the busy/stall timing.
module tb_md_unit_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start_E;
    logic [3:0]  op_E;
    logic [31:0] a_E;
    logic [31:0] b_E;
    logic        md_inst_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_E   (start_E),
        .op_E      (op_E),
        .a_E       (a_E),
        .b_E       (b_E),
        .md_inst_D (md_inst_D),
        .busy      (busy),
        .stall_md  (stall_md),
        .hi        (hi),
        .lo        (lo),
        .md_rdata  (md_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The hazard unit must never present a new MD op while the unit is busy.
    always @(negedge clk) begin
        if (start_E === 1'b1) begin
            checks++;
            assert (busy !== 1'b1) else begin
                errors++;
                $error("FAIL start_while_busy observed busy=%b expected busy=0", busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        logic [63:0]     q64;
        logic [63:0]     r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = {cur_hi, cur_lo};
        case (op)
            4'd1: r = sa * sb;
            4'd2: r = ua * ub;
            4'd3: if (b != 32'd0) begin
                sq = sa / sb;
                sr = sa % sb;
                q64 = sq;
                r64 = sr;
                r = {r64[31:0], q64[31:0]};
            end
            4'd4: if (b != 32'd0) begin
                uq = ua / ub;
                ur = ua % ub;
                q64 = uq;
                r64 = ur;
                r = {r64[31:0], q64[31:0]};
            end
            default: r = {cur_hi, cur_lo};
        endcase
        return r;
    endfunction

    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic md);
        logic [63:0] r;
        int n;
        n = (op == 4'd1 || op == 4'd2) ? MC : DC;
        r = ref_md(op, a, b, exp_hi, exp_lo);
        start_E = 1'b1; op_E = op; a_E = a; b_E = b; md_inst_D = md;
        #1;
        chk("stall_in_E", {31'd0, stall_md}, {31'd0, md});
        chk("busy_pre", {31'd0, busy}, 32'd0);
        chk("rdata_long", md_rdata, 32'd0);
        tick();
        start_E = 1'b0; op_E = 4'd0; a_E = $urandom; b_E = $urandom;
        #1;
        for (int i = 0; i < n; i++) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("stall_run", {31'd0, stall_md}, {31'd0, md});
            chk("hi_hold", hi, exp_hi);
            chk("lo_hold", lo, exp_lo);
            tick();
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("stall_done", {31'd0, stall_md}, 32'd0);
        chk("hi_commit", hi, exp_hi);
        chk("lo_commit", lo, exp_lo);
    endtask

    task automatic short_op(input logic [3:0] op, input logic [31:0] a, input logic md);
        logic [31:0] exp_rd;
        start_E = 1'b1; op_E = op; a_E = a; b_E = $urandom; md_inst_D = md;
        #1;
        exp_rd = (op == 4'd7) ? exp_hi : ((op == 4'd8) ? exp_lo : 32'd0);
        chk("rdata", md_rdata, exp_rd);
        chk("stall_short", {31'd0, stall_md}, 32'd0);
        tick();
        start_E = 1'b0; op_E = 4'd0;
        if (op == 4'd5) exp_hi = a;
        if (op == 4'd6) exp_lo = a;
        #1;
        chk("busy_short", {31'd0, busy}, 32'd0);
        chk("hi_short", hi, exp_hi);
        chk("lo_short", lo, exp_lo);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        rmd;
        reset = 1'b1; start_E = 1'b0; op_E = 4'd0; a_E = 32'd0; b_E = 32'd0; md_inst_D = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run_long(4'd1, 32'hFFFFFFFD, 32'd5, 1'b1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        run_long(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        short_op(4'd7, 32'd0, 1'b0);
        start_E = 1'b1; op_E = 4'd7; #1;
        chk("mfhi_const", md_rdata, 32'd1);
        start_E = 1'b0; op_E = 4'd0;
        tick();

        run_long(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        run_long(4'd4, 32'h00001234, 32'd0, 1'b0);
        chk("divz_hi", hi, 32'hFFFFFFFF);
        chk("divz_lo", lo, 32'hFFFFFFFD);
        run_long(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);

        short_op(4'd5, 32'h12345678, 1'b1);
        short_op(4'd6, 32'h9ABCDEF0, 1'b0);
        chk("mthi_const", hi, 32'h12345678);
        chk("mtlo_const", lo, 32'h9ABCDEF0);
        short_op(4'd0, 32'hDEADBEEF, 1'b1);

        // Reset in the third busy cycle of a MULT aborts with no commit.
        start_E = 1'b1; op_E = 4'd1; a_E = 32'd3; b_E = 32'd7; md_inst_D = 1'b0;
        tick();
        start_E = 1'b0; op_E = 4'd0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_hi", hi, 32'd0);
            chk("post_rst_lo", lo, 32'd0);
        end

        for (int k = 0; k < 30; k++) begin
            rop = 4'($urandom_range(0, 8));
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 17));
                default: rb = $urandom;
            endcase
            rmd = 1'($urandom_range(0, 1));
            if (rop >= 4'd1 && rop <= 4'd4) begin
                run_long(rop, ra, rb, rmd);
            end else begin
                short_op(rop, ra, rmd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
